// File: rtl/ami_pkg.sv
// ami_pkg: shared port-index/credit types and AXI response codes for the multi-port read adapter
package ami_pkg;
    localparam int MAX_PORTS = 8;
    typedef logic [$clog2(MAX_PORTS)-1:0] port_idx_t;
    typedef logic [15:0] credit_t;
    localparam logic [1:0] OKAY   = 2'd0;
    localparam logic [1:0] EXOKAY = 2'd1;
    localparam logic [1:0] SLVERR = 2'd2;
    localparam logic [1:0] DECERR = 2'd3;
    function automatic credit_t beats(input int len);
        return credit_t'(len + 1);
    endfunction
endpackage

// File: rtl/ami_sfifo.sv
// ami_sfifo: single-clock first-word-fall-through FIFO with zero-cycle read latency
module ami_sfifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);
    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wp, rp;
    assign empty = wp == rp;
    assign full  = wp == {~rp[AW], rp[AW-1:0]};
    assign dout  = mem[rp[AW-1:0]];
    // pointers wrap with an extra lap bit so full and empty are distinguishable
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + (AW+1)'(1);
            if (pop && !empty) rp <= rp + (AW+1)'(1);
        end
    end
    // storage is not reset; validity comes from the pointers
    always_ff @(posedge clk)
        if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/ami_r_mp.sv
// ami_r_mp: credit-based round-robin multiplexer of NPORT AXI read ports onto one AXI read master
module ami_r_mp
    import ami_pkg::*;
#(
    parameter int AXI_DW     = 128,
    parameter int AXI_AW     = 32,
    parameter int AXI_IW     = 8,
    parameter int AXI_LW     = 8,
    parameter int AXI_SW     = 3,
    parameter int AXI_BURSTW = 2,
    parameter int AXI_RRESPW = 2,
    parameter int NPORT      = 2,
    parameter int AMI_OD     = 4,
    parameter int AMI_RD     = 64
) (
    input  logic                                ACLK,
    input  logic                                ARESET,
    output logic [AXI_IW-1:0]                   ARID,
    output logic [AXI_AW-1:0]                   ARADDR,
    output logic [AXI_LW-1:0]                   ARLEN,
    output logic [AXI_SW-1:0]                   ARSIZE,
    output logic [AXI_BURSTW-1:0]               ARBURST,
    output logic                                ARVALID,
    input  logic                                ARREADY,
    input  logic [AXI_IW-1:0]                   RID,
    input  logic [AXI_DW-1:0]                   RDATA,
    input  logic [AXI_RRESPW-1:0]               RRESP,
    input  logic                                RLAST,
    input  logic                                RVALID,
    output logic                                RREADY,
    input  logic [NPORT-1:0][AXI_IW-1:0]        usr_arid,
    input  logic [NPORT-1:0][AXI_AW-1:0]        usr_araddr,
    input  logic [NPORT-1:0][AXI_LW-1:0]        usr_arlen,
    input  logic [NPORT-1:0][AXI_SW-1:0]        usr_arsize,
    input  logic [NPORT-1:0][AXI_BURSTW-1:0]    usr_arburst,
    input  logic [NPORT-1:0]                    usr_arvalid,
    output logic [NPORT-1:0]                    usr_arready,
    output logic [NPORT-1:0][AXI_IW-1:0]        usr_rid,
    output logic [NPORT-1:0][AXI_DW-1:0]        usr_rdata,
    output logic [NPORT-1:0][AXI_RRESPW-1:0]    usr_rresp,
    output logic [NPORT-1:0]                    usr_rlast,
    output logic [NPORT-1:0]                    usr_rvalid,
    input  logic [NPORT-1:0]                    usr_rready
);
    localparam int PW = $clog2(NPORT);
    localparam int RW = AXI_IW + AXI_DW + AXI_RRESPW + 1;
    localparam int OW = $clog2(AMI_OD + 1);

    credit_t                credit [NPORT];
    logic [OW-1:0]          outst;
    port_idx_t              rr, gnt_idx;
    logic [PW-1:0]          gsel, tgt;
    logic                   gnt, r_hs, tgt_ok;
    logic [MAX_PORTS-1:0]   elig;
    logic [NPORT-1:0]       push, pop, full, empty;
    logic [RW-1:0]          fifo_out [NPORT];

    // a port may compete only when its R buffer has room for the whole burst
    always_comb begin
        elig = '0;
        for (int p = 0; p < NPORT; p++)
            elig[p] = usr_arvalid[p] && credit[p] >= beats(int'(usr_arlen[p]));
    end

    // round-robin search starting after the last winner; the AR slot must be free or draining this cycle
    always_comb begin
        gnt     = 1'b0;
        gnt_idx = '0;
        for (int i = 1; i <= NPORT; i++)
            if (!gnt && elig[port_idx_t'((int'(rr) + i) % NPORT)]) begin
                gnt     = 1'b1;
                gnt_idx = port_idx_t'((int'(rr) + i) % NPORT);
            end
        gnt = gnt && !ARESET && (!ARVALID || ARREADY) && outst < OW'(AMI_OD);
    end

    assign gsel        = gnt_idx[PW-1:0];
    assign usr_arready = gnt ? NPORT'(1) << gnt_idx : '0;

    // AR register: loads on grant, holds payload until accepted; low ID bits tag the source port
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ARVALID <= 1'b0;
            ARID    <= '0;
            ARADDR  <= '0;
            ARLEN   <= '0;
            ARSIZE  <= '0;
            ARBURST <= '0;
            rr      <= port_idx_t'(NPORT - 1);
        end else if (gnt) begin
            ARVALID <= 1'b1;
            ARID    <= {usr_arid[gsel][AXI_IW-1:PW], gsel};
            ARADDR  <= usr_araddr[gsel];
            ARLEN   <= usr_arlen[gsel];
            ARSIZE  <= usr_arsize[gsel];
            ARBURST <= usr_arburst[gsel];
            rr      <= gnt_idx;
        end else if (ARREADY) begin
            ARVALID <= 1'b0;
        end
    end

    // credits reserve buffer space at grant and return it beat by beat as users drain their FIFO
    always_ff @(posedge ACLK)
        for (int p = 0; p < NPORT; p++)
            credit[p] <= ARESET ? credit_t'(AMI_RD)
                       : credit[p] - ((gnt && gnt_idx == port_idx_t'(p)) ? beats(int'(usr_arlen[p])) : '0)
                         + credit_t'(pop[p]);

    // bursts in flight: counted from grant until the last R beat is taken
    always_ff @(posedge ACLK)
        outst <= ARESET ? '0 : outst + OW'(gnt) - OW'(r_hs && RLAST);

    assign tgt    = RID[PW-1:0];
    assign tgt_ok = int'(tgt) < NPORT;
    assign RREADY = tgt_ok ? !full[tgt] : 1'b1;
    assign r_hs   = RVALID && RREADY;

    for (genvar g = 0; g < NPORT; g++) begin : g_port
        assign push[g]       = r_hs && tgt == PW'(g);
        assign pop[g]        = !empty[g] && usr_rready[g];
        assign usr_rvalid[g] = !empty[g];
        assign {usr_rid[g], usr_rdata[g], usr_rresp[g], usr_rlast[g]} = fifo_out[g];
        ami_sfifo #(.DW(RW), .DEPTH(AMI_RD)) u_fifo (
            .clk   (ACLK),
            .rst   (ARESET),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   ({RID, RDATA, RRESP, RLAST}),
            .dout  (fifo_out[g]),
            .full  (full[g]),
            .empty (empty[g])
        );
    end
endmodule

// File: tb/tb_ami_r_mp.sv
// tb_ami_r_mp: randomized self-checking bench with a transaction-level model of arbitration, credits and R routing
module tb_ami_r_mp;
    localparam int NP = 2;
    localparam int OD = 4;
    localparam int RD = 64;

    typedef struct {
        logic [7:0] id;
        int         left;
    } burst_t;
    typedef struct {
        logic [7:0]   id;
        logic [127:0] data;
        logic [1:0]   resp;
        logic         last;
    } beat_t;

    logic                    ACLK = 1'b0;
    logic                    ARESET = 1'b1;
    logic [7:0]              ARID;
    logic [31:0]             ARADDR;
    logic [7:0]              ARLEN;
    logic [2:0]              ARSIZE;
    logic [1:0]              ARBURST;
    logic                    ARVALID;
    logic                    ARREADY = 1'b0;
    logic [7:0]              RID = '0;
    logic [127:0]            RDATA = '0;
    logic [1:0]              RRESP = '0;
    logic                    RLAST = 1'b0;
    logic                    RVALID = 1'b0;
    logic                    RREADY;
    logic [NP-1:0][7:0]      usr_arid = '0;
    logic [NP-1:0][31:0]     usr_araddr = '0;
    logic [NP-1:0][7:0]      usr_arlen = '0;
    logic [NP-1:0][2:0]      usr_arsize = '0;
    logic [NP-1:0][1:0]      usr_arburst = '0;
    logic [NP-1:0]           usr_arvalid = '0;
    logic [NP-1:0]           usr_arready;
    logic [NP-1:0][7:0]      usr_rid;
    logic [NP-1:0][127:0]    usr_rdata;
    logic [NP-1:0][1:0]      usr_rresp;
    logic [NP-1:0]           usr_rlast;
    logic [NP-1:0]           usr_rvalid;
    logic [NP-1:0]           usr_rready = '0;

    int n_chk = 0;
    int n_fail = 0;

    int          credit [NP];
    int          outst, last_g;
    bit          ar_full;
    logic [7:0]  ar_id_m, ar_len_m;
    logic [31:0] ar_addr_m;
    logic [2:0]  ar_size_m;
    bit          req_on [NP];
    logic [7:0]  rq_id [NP], rq_len [NP];
    logic [31:0] rq_addr [NP];
    logic [2:0]  rq_size [NP];
    burst_t      sl_q [$];
    beat_t       exp_q [NP][$];

    ami_r_mp dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .usr_arid(usr_arid), .usr_araddr(usr_araddr), .usr_arlen(usr_arlen), .usr_arsize(usr_arsize),
        .usr_arburst(usr_arburst), .usr_arvalid(usr_arvalid), .usr_arready(usr_arready),
        .usr_rid(usr_rid), .usr_rdata(usr_rdata), .usr_rresp(usr_rresp), .usr_rlast(usr_rlast),
        .usr_rvalid(usr_rvalid), .usr_rready(usr_rready)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        ARESET      = 1'b1;
        usr_arvalid = '0;
        RVALID      = 1'b0;
        ARREADY     = 1'($urandom);
        usr_rready  = '0;
        #1 chk("arready_in_reset", usr_arready, 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        for (int p = 0; p < NP; p++) begin
            credit[p] = RD;
            req_on[p] = 0;
            exp_q[p].delete();
        end
        outst   = 0;
        last_g  = NP - 1;
        ar_full = 0;
        sl_q.delete();
        #1;
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_arid", ARID, 0);
        chk("rst_araddr", ARADDR, 0);
        chk("rst_arlen", ARLEN, 0);
        chk("rst_usr_arready", usr_arready, 0);
        chk("rst_usr_rvalid", usr_rvalid, 0);
        chk("rst_rready", RREADY, 1);
    endtask

    // one clock of stimulus: probabilities in percent for new requests, ARREADY, an R beat and user RREADY
    task automatic step(input int p_req, input int len_lo, input int len_hi, input int p_ar, input int p_rv, input int p_rr);
        int     g, k;
        beat_t  b;
        burst_t t;
        @(negedge ACLK);
        for (int p = 0; p < NP; p++) begin
            if (!req_on[p] && int'($urandom_range(99)) < p_req) begin
                req_on[p]  = 1;
                rq_id[p]   = 8'($urandom);
                rq_len[p]  = 8'($urandom_range(len_hi, len_lo));
                rq_addr[p] = $urandom;
                rq_size[p] = 3'($urandom_range(4));
            end
            usr_arvalid[p] = req_on[p];
            usr_arid[p]    = rq_id[p];
            usr_arlen[p]   = rq_len[p];
            usr_araddr[p]  = rq_addr[p];
            usr_arsize[p]  = rq_size[p];
            usr_arburst[p] = 2'd1;
            usr_rready[p]  = int'($urandom_range(99)) < p_rr;
        end
        ARREADY = int'($urandom_range(99)) < p_ar;
        RVALID  = 1'b0;
        k = 0;
        if (sl_q.size() > 0 && int'($urandom_range(99)) < p_rv) begin
            k = int'($urandom_range(sl_q.size() - 1));
            for (int j = 0; j < k; j++)
                if (sl_q[j].id == sl_q[k].id) begin
                    k = j;
                    break;
                end
            RID    = sl_q[k].id;
            RDATA  = {$urandom, $urandom, $urandom, $urandom};
            RRESP  = 2'($urandom);
            RLAST  = sl_q[k].left == 1;
            RVALID = 1'b1;
        end
        #1;
        g = -1;
        if (outst < OD && (!ar_full || ARREADY))
            for (int i = 1; i <= NP; i++) begin
                int p;
                p = (last_g + i) % NP;
                if (g < 0 && req_on[p] && credit[p] >= int'(rq_len[p]) + 1) g = p;
            end
        chk("usr_arready", usr_arready, g >= 0 ? 128'(1) << g : 128'(0));
        chk("arvalid", ARVALID, ar_full);
        if (ar_full) begin
            chk("arid", ARID, ar_id_m);
            chk("araddr", ARADDR, ar_addr_m);
            chk("arlen", ARLEN, ar_len_m);
            chk("arsize", ARSIZE, ar_size_m);
        end
        if (RVALID) chk("rready", RREADY, 1);
        for (int p = 0; p < NP; p++) begin
            chk("usr_rvalid", usr_rvalid[p], exp_q[p].size() != 0);
            if (exp_q[p].size() != 0) begin
                chk("usr_rdata", usr_rdata[p], exp_q[p][0].data);
                chk("usr_rid", usr_rid[p], exp_q[p][0].id);
                chk("usr_rlast", usr_rlast[p], exp_q[p][0].last);
                chk("usr_rresp", usr_rresp[p], exp_q[p][0].resp);
            end
        end
        if (ar_full && ARREADY) begin
            sl_q.push_back('{ar_id_m, int'(ar_len_m) + 1});
            ar_full = 0;
        end
        if (g >= 0) begin
            ar_full   = 1;
            ar_id_m   = {rq_id[g][7:1], g[0]};
            ar_addr_m = rq_addr[g];
            ar_len_m  = rq_len[g];
            ar_size_m = rq_size[g];
            credit[g] -= int'(rq_len[g]) + 1;
            outst++;
            last_g    = g;
            req_on[g] = 0;
        end
        for (int p = 0; p < NP; p++)
            if (exp_q[p].size() != 0 && usr_rready[p]) begin
                void'(exp_q[p].pop_front());
                credit[p]++;
            end
        if (RVALID) begin
            b = '{RID, RDATA, RRESP, RLAST};
            exp_q[RID[0]].push_back(b);
            t = sl_q[k];
            t.left--;
            sl_q[k] = t;
            if (RLAST) begin
                sl_q.delete(k);
                outst--;
            end
        end
    endtask

    initial begin
        int pq, lh, pa, pv, pr;
        do_reset();
        repeat (30) step(100, 3, 3, 100, 0, 100);
        repeat (80) step(0, 0, 0, 100, 100, 100);
        repeat (15) step(100, 0, 15, 0, 60, 100);
        repeat (12) step(100, 63, 63, 100, 0, 0);
        repeat (60) step(0, 0, 0, 100, 100, 0);
        repeat (40) step(100, 0, 0, 100, 100, 30);
        repeat (200) step(0, 0, 0, 100, 100, 100);
        for (int r = 0; r < 8; r++) begin
            pq = int'($urandom_range(100));
            lh = int'($urandom_range(63));
            pa = int'($urandom_range(100, 20));
            pv = int'($urandom_range(100, 20));
            pr = int'($urandom_range(100));
            repeat (300) step(pq, 0, lh, pa, pv, pr);
        end
        repeat (10) step(100, 3, 3, 100, 0, 100);
        do_reset();
        repeat (5) step(100, 63, 63, 100, 0, 100);
        repeat (400) step(0, 0, 0, 100, 100, 100);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
